// File: rtl/lc3b_types.sv
// Shared types for the memory arbiter: data words, byte masks, FSM state
// encoding and the latched request record.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } arb_port_t;

    // One memory request as presented to the memory side.
    typedef struct packed {
        logic          read;
        logic          write;
        lc3b_mem_wmask wmask;
        lc3b_word      address;
        lc3b_word      wdata;
    } mem_req_t;

    localparam mem_req_t MEM_REQ_NONE = '0;

    // Build a request record; a port asserting both read and write is a write.
    function automatic mem_req_t make_req(
        input logic          rd,
        input logic          wr,
        input lc3b_mem_wmask mask,
        input lc3b_word      addr,
        input lc3b_word      data
    );
        mem_req_t r;
        r.read    = rd & ~wr;
        r.write   = wr;
        r.wmask   = mask;
        r.address = addr;
        r.wdata   = data;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_control.sv
// Arbiter FSM: picks which port owns the memory, drives the memory strobes
// from the latched request kind and generates the per-port completion pulses.
module mem_arbiter_control
    import lc3b_types::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic pend_a,
    input  logic pend_b,
    input  logic req_read,
    input  logic req_write,
    input  logic mem_resp,
    output logic grant_a,
    output logic grant_b,
    output logic mem_read,
    output logic mem_write,
    output logic resp_a,
    output logic resp_b
);

    arb_state_t state_q, state_d;
    arb_port_t  last_grant_q, last_grant_d;

    // State and last-grant registers; B counts as last granted out of reset so A wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_B;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state: arbitrate in IDLE, hold a transaction until memory completes it.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (pend_a && pend_b) begin
                    if (ROUND_ROBIN != 0) begin
                        state_d = (last_grant_q == PORT_B) ? SERVE_A : SERVE_B;
                    end else begin
                        state_d = SERVE_B;
                    end
                end else if (pend_a) begin
                    state_d = SERVE_A;
                end else if (pend_b) begin
                    state_d = SERVE_B;
                end
            end
            SERVE_A: begin
                if (mem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = PORT_A;
                end
            end
            SERVE_B: begin
                if (mem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = PORT_B;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: grant pulses mark the latch edge, strobes follow the latched kind, resp mirrors mem_resp.
    always_comb begin
        grant_a   = (state_q == IDLE) && (state_d == SERVE_A);
        grant_b   = (state_q == IDLE) && (state_d == SERVE_B);
        mem_read  = (state_q != IDLE) && req_read;
        mem_write = (state_q != IDLE) && req_write;
        resp_a    = (state_q == SERVE_A) && mem_resp;
        resp_b    = (state_q == SERVE_B) && mem_resp;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port to single-port memory arbiter. Port A is the instruction side,
// port B the data side. The granted request is captured in a register so the
// memory sees a stable request for the whole transaction.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          read_a,
    input  logic          write_a,
    input  lc3b_mem_wmask wmask_a,
    input  lc3b_word      address_a,
    input  lc3b_word      wdata_a,
    output logic          resp_a,
    output lc3b_word      rdata_a,
    input  logic          read_b,
    input  logic          write_b,
    input  lc3b_mem_wmask wmask_b,
    input  lc3b_word      address_b,
    input  lc3b_word      wdata_b,
    output logic          resp_b,
    output lc3b_word      rdata_b,
    output logic          mem_read,
    output logic          mem_write,
    output lc3b_mem_wmask mem_wmask,
    output lc3b_word      mem_address,
    output lc3b_word      mem_wdata,
    input  logic          mem_resp,
    input  lc3b_word      mem_rdata
);

    logic [1:0] port_read;
    logic [1:0] port_write;
    logic [1:0] port_pend;
    logic [1:0] port_resp;
    lc3b_word   port_rdata [2];

    logic       grant_a;
    logic       grant_b;
    mem_req_t   req_q, req_d;

    assign port_read  = {read_b, read_a};
    assign port_write = {write_b, write_a};
    assign port_resp  = {resp_b, resp_a};

    // Per-port pending detection and read-data gating (zero unless completing).
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign port_pend[gi]  = port_read[gi] | port_write[gi];
        assign port_rdata[gi] = port_resp[gi] ? mem_rdata : '0;
    end

    assign rdata_a = port_rdata[0];
    assign rdata_b = port_rdata[1];

    mem_arbiter_control #(
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_control (
        .clk       (clk),
        .reset     (reset),
        .pend_a    (port_pend[0]),
        .pend_b    (port_pend[1]),
        .req_read  (req_q.read),
        .req_write (req_q.write),
        .mem_resp  (mem_resp),
        .grant_a   (grant_a),
        .grant_b   (grant_b),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .resp_a    (resp_a),
        .resp_b    (resp_b)
    );

    // Select which port's request to capture; otherwise keep the one in flight.
    always_comb begin
        req_d = req_q;
        if (grant_a) begin
            req_d = make_req(read_a, write_a, wmask_a, address_a, wdata_a);
        end else if (grant_b) begin
            req_d = make_req(read_b, write_b, wmask_b, address_b, wdata_b);
        end
    end

    // Request register; changes on the requesting ports after the grant cannot reach memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= MEM_REQ_NONE;
        end else begin
            req_q <= req_d;
        end
    end

    assign mem_wmask   = req_q.wmask;
    assign mem_address = req_q.address;
    assign mem_wdata   = req_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance for most scenarios,
// fixed-priority instance for the starvation scenario. Expected transactions
// are queued when requests are driven and consumed as the memory side runs.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        read_a, write_a, read_b, write_b;
    logic [1:0]  wmask_a, wmask_b;
    logic [15:0] address_a, wdata_a, address_b, wdata_b;

    logic        resp_a, resp_b;
    logic [15:0] rdata_a, rdata_b;
    logic        mem_read, mem_write;
    logic [1:0]  mem_wmask;
    logic [15:0] mem_address, mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    logic        fp_resp_a, fp_resp_b;
    logic [15:0] fp_rdata_a, fp_rdata_b;
    logic        fp_mem_read, fp_mem_write;
    logic [1:0]  fp_mem_wmask;
    logic [15:0] fp_mem_address, fp_mem_wdata;
    logic        mem_resp_fp;
    logic [15:0] mem_rdata_fp;

    mem_arbiter #(.ROUND_ROBIN(1)) dut (
        .clk(clk), .reset(reset),
        .read_a(read_a), .write_a(write_a), .wmask_a(wmask_a), .address_a(address_a),
        .wdata_a(wdata_a), .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
        .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .reset(reset),
        .read_a(read_a), .write_a(write_a), .wmask_a(wmask_a), .address_a(address_a),
        .wdata_a(wdata_a), .resp_a(fp_resp_a), .rdata_a(fp_rdata_a),
        .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
        .wdata_b(wdata_b), .resp_b(fp_resp_b), .rdata_b(fp_rdata_b),
        .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_wmask(fp_mem_wmask),
        .mem_address(fp_mem_address), .mem_wdata(fp_mem_wdata),
        .mem_resp(mem_resp_fp), .mem_rdata(mem_rdata_fp)
    );

    typedef struct {
        bit          port_b;
        bit          write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  wmask;
        int          lat;
        logic [15:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    int   tests_run = 0;
    int   failures  = 0;
    bit   poke      = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit pb, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [1:0] m,
                        input int lat, input logic [15:0] rd);
        txn_t t;
        t.port_b = pb; t.write = wr; t.addr = addr; t.wdata = wd;
        t.wmask = m; t.lat = lat; t.rdata = rd;
        exp_q.push_back(t);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Serve one transaction on the round-robin instance; called at the negedge the request is visible.
    task automatic run_txn();
        txn_t t;
        int   waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(mem_read || mem_write) && waited < 8);
        chk("grant_latency", waited, 1);
        if (exp_q.size() == 0) begin
            tests_run++;
            failures++;
            $error("FAIL scoreboard_empty observed=strobe expected=no_transaction");
            return;
        end
        t = exp_q.pop_front();
        for (int i = 1; i <= t.lat; i++) begin
            chk("mem_read", mem_read, !t.write);
            chk("mem_write", mem_write, t.write);
            chk("mem_address", mem_address, t.addr);
            if (t.write) begin
                chk("mem_wdata", mem_wdata, t.wdata);
                chk("mem_wmask", mem_wmask, t.wmask);
            end
            if (i < t.lat) begin
                chk("resp_a_wait", resp_a, 0);
                chk("resp_b_wait", resp_b, 0);
                if (poke && i == 1) begin
                    address_a = 16'h5000;
                    read_b    = 1'b1;
                end
                if (poke && i == 2) read_b = 1'b0;
                @(negedge clk);
            end
        end
        mem_resp  = 1'b1;
        mem_rdata = t.rdata;
        #1;
        chk("resp_a", resp_a, !t.port_b);
        chk("resp_b", resp_b, t.port_b);
        chk("rdata_a", rdata_a, t.port_b ? 16'h0000 : t.rdata);
        chk("rdata_b", rdata_b, t.port_b ? t.rdata : 16'h0000);
        $display("[TB] txn port=%s %s addr=0x%04h rdata=0x%04h", t.port_b ? "B" : "A",
                 t.write ? "write" : "read", t.addr, t.rdata);
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = 16'hFFFF;
        if (t.port_b) begin
            read_b = 1'b0; write_b = 1'b0;
        end else begin
            read_a = 1'b0; write_a = 1'b0;
        end
        #1;
        chk("gap_strobe", mem_read | mem_write, 0);
        chk("gap_resp", resp_a | resp_b, 0);
        chk("gap_rdata", {rdata_a, rdata_b}, 0);
    endtask

    initial begin
        txn_t t;
        int   waited;

        reset = 1'b1;
        read_a = 0; write_a = 0; wmask_a = 0; address_a = 0; wdata_a = 0;
        read_b = 0; write_b = 0; wmask_b = 0; address_b = 0; wdata_b = 0;
        mem_resp = 0; mem_rdata = 0; mem_resp_fp = 0; mem_rdata_fp = 0;

        // Reset state.
        do_reset();
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_resp", {resp_a, resp_b}, 0);
        chk("rst_req_regs", {mem_address, mem_wdata, 14'd0, mem_wmask}, 0);
        $display("[TB] reset released");

        // A reads 0x3000 alone, memory answers in the third strobe cycle.
        read_a = 1'b1; address_a = 16'h3000;
        push(0, 0, 16'h3000, 16'h0000, 2'b00, 3, 16'h1234);
        run_txn();

        // Contention straight out of reset: A first, then B's write.
        do_reset();
        read_a = 1'b1; address_a = 16'h3100;
        write_b = 1'b1; address_b = 16'h4002; wdata_b = 16'h00FF; wmask_b = 2'b01;
        push(0, 0, 16'h3100, 16'h0000, 2'b00, 2, 16'h0A0A);
        push(1, 1, 16'h4002, 16'h00FF, 2'b01, 1, 16'hDEAD);
        run_txn();
        run_txn();

        // Port inputs wiggle while A is served; latched request must hold.
        read_a = 1'b1; address_a = 16'h3000;
        poke = 1'b1;
        push(0, 0, 16'h3000, 16'h0000, 2'b00, 3, 16'h4321);
        run_txn();
        poke = 1'b0;

        // Last grant was A, so the tie goes to B; B's read+write is a write.
        read_a = 1'b1; address_a = 16'h3200;
        read_b = 1'b1; write_b = 1'b1; address_b = 16'h6000; wdata_b = 16'hBEEF; wmask_b = 2'b10;
        push(1, 1, 16'h6000, 16'hBEEF, 2'b10, 2, 16'h0F0F);
        push(0, 0, 16'h3200, 16'h0000, 2'b00, 1, 16'h5555);
        run_txn();
        run_txn();

        // A stray mem_resp in IDLE is ignored.
        mem_resp = 1'b1; mem_rdata = 16'h7777;
        #1;
        chk("idle_resp", {resp_a, resp_b}, 0);
        chk("idle_rdata", {rdata_a, rdata_b}, 0);
        @(negedge clk);
        mem_resp = 1'b0;
        #1;
        chk("idle_stay", mem_read | mem_write, 0);
        $display("[TB] stray mem_resp in IDLE");

        // Reset in the second SERVE_B cycle abandons the transaction.
        read_b = 1'b1; write_b = 1'b0; address_b = 16'h7000;
        @(negedge clk);
        chk("abort_cyc1_read", mem_read, 1);
        chk("abort_cyc1_addr", mem_address, 16'h7000);
        @(negedge clk);
        chk("abort_cyc2_read", mem_read, 1);
        reset = 1'b1; read_b = 1'b0;
        @(negedge clk);
        reset = 1'b0; mem_resp = 1'b1; mem_rdata = 16'hABCD;
        #1;
        chk("abort_no_resp", {resp_a, resp_b}, 0);
        chk("abort_rdata_b", rdata_b, 0);
        chk("abort_strobe", mem_read | mem_write, 0);
        chk("abort_addr_clr", mem_address, 0);
        @(negedge clk);
        mem_resp = 1'b0;
        #1;
        chk("abort_idle", mem_read | mem_write, 0);
        $display("[TB] reset during SERVE_B");

        // Normal A request after the abort.
        read_a = 1'b1; address_a = 16'h3300;
        push(0, 0, 16'h3300, 16'h0000, 2'b00, 2, 16'h2468);
        run_txn();

        // Fixed-priority instance: both ports held, B takes every grant.
        do_reset();
        read_a = 1'b1; address_a = 16'h1000;
        read_b = 1'b1; write_b = 1'b0; address_b = 16'h2000;
        for (int k = 0; k < 4; k++) push(1, 0, 16'h2000, 16'h0000, 2'b00, 1, 16'hC000 + 16'(k));
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
                if (!fp_mem_read) chk("fp_resp_a_idle", fp_resp_a, 0);
            end while (!fp_mem_read && waited < 8);
            chk("fp_latency", waited, 1);
            if (exp_q.size() == 0) begin
                tests_run++;
                failures++;
                $error("FAIL fp_scoreboard_empty observed=strobe expected=no_transaction");
                break;
            end
            t = exp_q.pop_front();
            chk("fp_mem_address", fp_mem_address, t.addr);
            mem_resp_fp = 1'b1; mem_rdata_fp = t.rdata;
            #1;
            chk("fp_resp_b", fp_resp_b, t.port_b);
            chk("fp_resp_a", fp_resp_a, !t.port_b);
            chk("fp_rdata_b", fp_rdata_b, t.rdata);
            $display("[TB] fp txn port=B read addr=0x%04h rdata=0x%04h", t.addr, t.rdata);
            @(negedge clk);
            mem_resp_fp = 1'b0; mem_rdata_fp = 16'h0000;
            #1;
            chk("fp_gap", fp_mem_read | fp_mem_write, 0);
        end
        read_a = 1'b0; read_b = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1: 1 = alternate grants on contention; 0 = fixed priority to port B.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 read_a  input  1  port A (instruction side) read request, held until resp_a.
REQ-005 write_a  input  1  port A write request, held until resp_a.
REQ-006 wmask_a  input  2  port A byte-write mask.
REQ-007 address_a  input  16  port A byte address.
REQ-008 wdata_a  input  16  port A write data.
REQ-009 resp_a  output  1  port A completion, one-cycle pulse.
REQ-010 rdata_a  output  16  port A read data, valid when resp_a=1.
REQ-011 read_b, write_b, wmask_b, address_b, wdata_b, resp_b, rdata_b: port B (data side), same directions, widths and meanings as REQ-004..REQ-010.
REQ-012 mem_read  output  1  memory read strobe.
REQ-013 mem_write  output  1  memory write strobe.
REQ-014 mem_wmask  output  2  memory byte-write mask.
REQ-015 mem_address  output  16  memory address.
REQ-016 mem_wdata  output  16  memory write data.
REQ-017 mem_resp  input  1  memory completion, one-cycle pulse.
REQ-018 mem_rdata  input  16  memory read data, valid when mem_resp=1.

Function
REQ-019 States SHALL be IDLE, SERVE_A, SERVE_B.
REQ-020 A port is pending when its read or write input is 1; when read and write are both 1, the port SHALL be served as a write.
REQ-021 In IDLE, with only A pending, the arbiter SHALL go to SERVE_A at the next edge; with only B pending, to SERVE_B; with neither pending, it SHALL stay in IDLE.
REQ-022 In IDLE with both pending and ROUND_ROBIN=1, the arbiter SHALL grant the port not granted last (last_grant register, reset value B, so A wins the first contention); with ROUND_ROBIN=0, it SHALL grant B.
REQ-023 On the IDLE->SERVE_x edge, the arbiter SHALL latch address, wdata, wmask and the read/write kind of port x into request registers; mem_* outputs SHALL be driven only from these registers.
REQ-024 In SERVE_x, mem_read or mem_write SHALL be asserted according to the latched kind, held until mem_resp=1.
REQ-025 In SERVE_x, in the cycle mem_resp=1, resp_x SHALL be 1 combinationally and rdata_x SHALL equal mem_rdata; the other port's resp SHALL stay 0.
REQ-026 On the mem_resp edge, the arbiter SHALL return to IDLE, update last_grant to x, and deassert mem_read/mem_write the following cycle; minimum spacing between two memory transactions SHALL be one IDLE cycle.
REQ-027 Latency SHALL be one grant cycle plus the memory latency: the request is seen at edge n, memory strobes are asserted from cycle n+1, and resp arrives in the mem_resp cycle.
REQ-028 A request appearing or vanishing on the non-granted port during SERVE_x SHALL NOT affect the transaction in flight.
REQ-029 mem_resp in IDLE SHALL be ignored: no resp pulse and no state change.
REQ-030 rdata_a/rdata_b SHALL be 16'h0000 when the corresponding resp is 0.

Reset
REQ-031 When reset=1 at an edge, the arbiter SHALL set state to IDLE, last_grant to B and request registers to 0; mem_read, mem_write, resp_a and resp_b SHALL be 0 from the next cycle.
REQ-032 Reset during SERVE_x SHALL abandon the transaction with no resp pulse; a mem_resp arriving afterwards SHALL be ignored per REQ-029.

Structure
REQ-033 lc3b_word, lc3b_mem_wmask and the arbiter state enum SHALL live in package lc3b_types.
REQ-034 The FSM SHALL be in sub-module mem_arbiter_control (state, last_grant, grant/strobe/resp outputs); request registers and data muxing SHALL stay in mem_arbiter.

Verification
REQ-035 A reads 0x3000 alone, memory responds after 3 cycles with 0x1234 -> mem_read=1 with mem_address=0x3000 for 3 cycles, resp_a=1 with rdata_a=0x1234, resp_b=0 throughout.
REQ-036 A and B both pending from reset (B write 0x00FF to 0x4002, wmask 01) -> A served first, then B; mem_write=1, mem_wmask=01, mem_wdata=0x00FF; one IDLE cycle between the two transactions.
REQ-037 ROUND_ROBIN=0, A and B continuously pending for 4 transactions -> all 4 grants to B, resp_a never 1.
REQ-038 B asserts read_b=1 and write_b=1 -> memory sees a write only.
REQ-039 Reset asserted in the 2nd cycle of SERVE_B, mem_resp pulses 1 cycle later -> no resp_b, state IDLE, next A request served normally.
REQ-040 During SERVE_A, address_a changes from 0x3000 to 0x5000 -> mem_address stays 0x3000 until resp_a.
